// File: rtl/feature_map_writer.sv
// Strips the not-yet-full window border from a raster filter stream and writes kept samples to memory.
// Optional FEATURE_MAP_WRITER_STRIDE2_EN keeps only every other row/column of the valid region.
module feature_map_writer #(
  parameter int WIDTH  = 16,
  parameter int FN     = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     in_valid,
  input  logic signed [WIDTH-1:0]  din,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [WIDTH-1:0]  wr_data,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        wr_count,
  output logic                     orphan
);

  localparam int COL_W = 11;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(FN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [ADDR_W-1:0]         wr_count_q, wr_count_d;
  logic                      orphan_q, orphan_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
  logic signed [WIDTH-1:0]   wr_data_q, wr_data_d;

  // The window is full once both coordinates reach FN-1; stride mode also needs even offsets.
  function automatic logic keep_f(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
`ifdef FEATURE_MAP_WRITER_STRIDE2_EN
    return (row >= ROW_FIRST) && (col >= COL_FIRST) &&
           (row[0] == ROW_FIRST[0]) && (col[0] == COL_FIRST[0]);
`else
    return (row >= ROW_FIRST) && (col >= COL_FIRST);
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    addr_d     = addr_q;
    wr_count_d = wr_count_q;
    orphan_d   = orphan_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          row_d      = '0;
          col_d      = '0;
          wr_count_d = '0;
          orphan_d   = 1'b0;
          addr_d     = base_addr;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (keep_f(row_q, col_q)) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = din;
            addr_d     = addr_q + 1'b1;
            wr_count_d = wr_count_q + 1'b1;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST) state_d = DONE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A sample outside RUN is lost; this wins over the clear done by start.
    if (in_valid && (state_q != RUN)) orphan_d = 1'b1;
  end

  // Stage boundary: every output and counter is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      wr_count_q <= '0;
      orphan_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      wr_count_q <= wr_count_d;
      orphan_q   <= orphan_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_count = wr_count_q;
  assign orphan   = orphan_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_feature_map_writer.sv
// Directed bench for feature_map_writer on a 6x6 frame with a 3x3 window; scoreboard of expected writes.
module tb_feature_map_writer;

  localparam int WIDTH = 16, FN = 3, IMG_W = 6, IMG_H = 6, ADDR_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic [WIDTH-1:0]  din;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] wr_count;
  logic              orphan;

  feature_map_writer #(.WIDTH(WIDTH), .FN(FN), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .din(din), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .wr_count(wr_count), .orphan(orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   ncyc     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every wr_en must match the oldest expected write, in its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (wr_en !== 1'b0) begin
      n_assert++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write observed wr_en=%b addr=%0h expected no write", wr_en, wr_addr);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_cycle", 32'(ncyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_keep(input int r, input int c);
`ifdef FEATURE_MAP_WRITER_STRIDE2_EN
    return (r >= FN-1) && (c >= FN-1) && (((r-(FN-1)) % 2) == 0) && (((c-(FN-1)) % 2) == 0);
`else
    return (r >= FN-1) && (c >= FN-1);
`endif
  endfunction

  // Drives one frame of raster indices; nsamp < 36 leaves the frame partial.
  task automatic run_frame(input logic [ADDR_W-1:0] base, input int gap, input bit mid_start,
                           input bit start_valid, input int nsamp);
    logic [ADDR_W-1:0] a;
    int kept;
    exp_t e;
    a = base;
    kept = 0;
    start = 1'b1; base_addr = base; in_valid = start_valid; din = 16'h7777;
    tick();
    start = 1'b0; in_valid = 1'b0; base_addr = 16'h0200;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("wr_count_cleared", 32'(wr_count), 32'd0);
    chk("orphan_at_start", 32'(orphan), 32'(start_valid));
    for (int idx = 0; idx < nsamp; idx++) begin
      in_valid = 1'b1;
      din = WIDTH'(idx);
      if (mid_start && idx == 10) begin
        start = 1'b1;
        base_addr = 16'h0200;
      end
      if (model_keep(idx / IMG_W, idx % IMG_W)) begin
        e.cyc = ncyc + 2; e.addr = a; e.data = WIDTH'(idx);
        q.push_back(e);
        a = a + 1'b1;
        kept++;
      end
      tick();
      in_valid = 1'b0;
      start = 1'b0;
      if (idx != IMG_W*IMG_H-1)
        for (int g = 0; g < gap; g++) tick();
    end
    if (nsamp == IMG_W*IMG_H) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_after_last", 32'(busy), 32'd0);
      chk("wr_count_final", 32'(wr_count), 32'(kept));
      if (mid_start) begin
        start = 1'b1;
        base_addr = 16'h0200;
      end
      tick();
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
      chk("wr_count_hold", 32'(wr_count), 32'(kept));
      chk("queue_drained", 32'(q.size()), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; din = '0;
    #2;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_orphan", 32'(orphan), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Continuous stream from 0x100.
    run_frame(16'h0100, 0, 1'b0, 1'b0, IMG_W*IMG_H);
    // Alternating valid.
    run_frame(16'h0100, 1, 1'b0, 1'b0, IMG_W*IMG_H);

    // Samples in IDLE set the sticky orphan flag and never write.
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; din = 16'h00AA;
      tick();
      in_valid = 1'b0;
      chk("orphan_idle", 32'(orphan), 32'd1);
      tick();
    end
    run_frame(16'h0100, 0, 1'b0, 1'b0, IMG_W*IMG_H);
    chk("orphan_stays_clear", 32'(orphan), 32'd0);

    // Start with a coincident sample: frame runs, orphan is set.
    run_frame(16'h0300, 0, 1'b0, 1'b1, IMG_W*IMG_H);
    chk("orphan_start_valid", 32'(orphan), 32'd1);

    // Partial frame then asynchronous reset.
    run_frame(16'h0100, 0, 1'b0, 1'b0, 20);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_wr_data", 32'(wr_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_wr_count", 32'(wr_count), 32'd0);
    chk("midrst_queue", 32'(q.size()), 32'd0);
    q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_no_done", 32'(done), 32'd0);
    run_frame(16'h0000, 0, 1'b0, 1'b0, IMG_W*IMG_H);

    // Start during RUN and on the done cycle is ignored.
    run_frame(16'h0100, 0, 1'b1, 1'b0, IMG_W*IMG_H);

    // Address wrap near the top of the space.
    run_frame(16'hFFFA, 0, 1'b0, 1'b0, IMG_W*IMG_H);

    tick();
    chk("final_queue", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
